id_stage: RTL and testbench
===========================

ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 SHALL provide parameter REG_RST_VAL, default 8'h00, reset value loaded into every register-file entry.
REQ-002 SHALL provide port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL provide port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL provide port instr  input  8  instruction byte: [7:4] opcode, [3:2] ra, [1:0] rb; or immediate byte in S_IMM.
REQ-005 SHALL provide port instr_valid  input  1  instr holds a byte.
REQ-006 SHALL provide port instr_ready  output  1  stage accepts instr this cycle.
REQ-007 SHALL provide port flush  input  1  discard pending and held work (taken branch).
REQ-008 SHALL provide port wb_en  input  1  register-file write strobe.
REQ-009 SHALL provide port wb_addr  input  2  write index.
REQ-010 SHALL provide port wb_data  input  8  write data.
REQ-011 SHALL provide port s1  output  8  first ALU operand, R[ra].
REQ-012 SHALL provide port s2  output  8  second ALU operand, R[rb] or immediate.
REQ-013 SHALL provide port mode  output  4  ALU mode, equal to opcode.
REQ-014 SHALL provide port dest  output  2  ra of the held operation, for writeback.
REQ-015 SHALL provide port out_valid  output  1  s1/s2/mode/dest hold a decoded operation.
REQ-016 SHALL provide port out_ready  input  1  downstream consumes the held operation.

Function
REQ-017 SHALL hold a 4x8 register file; wb_en=1 writes wb_data to R[wb_addr] at the clock edge, regardless of stall, flush or FSM state.
REQ-018 SHALL drive instr_ready = !out_valid || out_ready (single-entry output register, no bubble on back-to-back transfers).
REQ-019 SHALL implement FSM states S_DEC and S_IMM; reset state is S_DEC.
REQ-020 In S_DEC on accept (instr_valid && instr_ready), opcode 1..E SHALL load s1=R[ra], s2=R[rb], mode=opcode, dest=ra and set out_valid the next cycle (latency 1).
REQ-021 In S_DEC, opcode 0 (NOP) SHALL be accepted and dropped: no output and out_valid cleared if it was being consumed.
REQ-022 In S_DEC, opcode F (LoadIMM) SHALL latch ra, move to S_IMM and produce no output.
REQ-023 In S_IMM on accept, the byte SHALL be used as immediate: s1=R[ra latched], s2=byte, mode=F, dest=ra latched, out_valid=1; FSM returns to S_DEC.
REQ-024 While out_valid && !out_ready, s1/s2/mode/dest SHALL remain stable; a writeback to a source register does not update held operands.
REQ-025 On out_ready with no new accept, out_valid SHALL clear the next cycle.
REQ-026 flush=1 SHALL clear out_valid and return the FSM to S_DEC at the next edge, dropping any latched LoadIMM; flush has priority over an accept in the same cycle (byte is consumed and discarded).
REQ-027 No arithmetic is performed; all operand paths are 8-bit unmodified copies.

Reset
REQ-028 While rst_n=0: out_valid=0, s1=s2=8'h00, mode=4'h0, dest=2'b00, FSM=S_DEC, all registers=REG_RST_VAL; applies immediately, including mid-LoadIMM.
REQ-029 instr_ready SHALL read 1 during and after reset (follows REQ-018).

Configuration
REQ-030 With ID_WB_BYPASS_EN defined, a read of R[x] in the same cycle as wb_en=1 to x SHALL return wb_data (write-before-read).
REQ-031 Without ID_WB_BYPASS_EN, that read SHALL return the old R[x]; the new value is visible from the next cycle.

Verification
REQ-032 Reset, then write R1=8'h05, R2=8'h03; send 8'h16 (mode 1, ra=1, rb=2) -> next cycle out_valid=1, s1=8'h05, s2=8'h03, mode=1, dest=1.
REQ-033 Send 8'hF8 then 8'h7F -> no output after first byte; after second: mode=F, dest=2, s2=8'h7F, out_valid=1.
REQ-034 Hold out_ready=0 with op held, apply wb to R1=8'hAA -> instr_ready=0, outputs unchanged; raise out_ready -> next op accepted same cycle.
REQ-035 Send 8'hF4, then flush=1 with instr_valid=1, 8'h22 -> out_valid=0, FSM in S_DEC; next 8'h26 decodes as mode 2.
REQ-036 wb_en=1 to R3=8'h11 in same cycle as accepting 8'h8F -> s2=8'h11 with ID_WB_BYPASS_EN, old R3 without.

Source files
------------

// File: rtl/id_stage.sv
// Instruction decode stage: 4x8 register file, LoadIMM two-byte FSM and a
// single-entry output register. Define ID_WB_BYPASS_EN for write-before-read.
module id_stage #(
  parameter logic [7:0] REG_RST_VAL = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] instr,
  input  logic       instr_valid,
  output logic       instr_ready,
  input  logic       flush,
  input  logic       wb_en,
  input  logic [1:0] wb_addr,
  input  logic [7:0] wb_data,
  output logic [7:0] s1,
  output logic [7:0] s2,
  output logic [3:0] mode,
  output logic [1:0] dest,
  output logic       out_valid,
  input  logic       out_ready
);

  localparam logic [0:0] S_DEC = 1'b0;
  localparam logic [0:0] S_IMM = 1'b1;
  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_IMM = 4'hF;

  typedef struct packed {
    logic [7:0] s1;
    logic [7:0] s2;
    logic [3:0] mode;
    logic [1:0] dest;
  } op_t;

  logic [3:0][7:0] rf;
  logic [0:0]      state;
  logic [1:0]      imm_ra;
  op_t             held;
  logic            vld;
  logic            accept;
  logic [3:0]      opcode;
  logic [1:0]      src_a;
  logic [1:0]      src_b;
  logic [7:0]      rd_a;
  logic [7:0]      rd_b;

  assign instr_ready = !vld || out_ready;
  assign accept      = instr_valid && instr_ready;
  assign opcode      = instr[7:4];
  // In S_IMM the first operand comes from the ra latched with the LoadIMM opcode.
  assign src_a       = (state == S_IMM) ? imm_ra : instr[3:2];
  assign src_b       = instr[1:0];

`ifdef ID_WB_BYPASS_EN
  assign rd_a = (wb_en && (wb_addr == src_a)) ? wb_data : rf[src_a];
  assign rd_b = (wb_en && (wb_addr == src_b)) ? wb_data : rf[src_b];
`else
  assign rd_a = rf[src_a];
  assign rd_b = rf[src_b];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf <= {4{REG_RST_VAL}};
    end else if (wb_en) begin
      rf[wb_addr] <= wb_data;
    end
  end

  // flush outranks accept: an accepted byte in a flush cycle is discarded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_DEC;
      imm_ra <= 2'b00;
      vld    <= 1'b0;
      held   <= '0;
    end else if (flush) begin
      state <= S_DEC;
      vld   <= 1'b0;
    end else if (accept) begin
      if (state == S_IMM) begin
        held  <= '{s1: rd_a, s2: instr, mode: OP_IMM, dest: imm_ra};
        vld   <= 1'b1;
        state <= S_DEC;
      end else begin
        case (opcode)
          OP_NOP: vld <= 1'b0;
          OP_IMM: begin
            imm_ra <= instr[3:2];
            state  <= S_IMM;
            vld    <= 1'b0;
          end
          default: begin
            held <= '{s1: rd_a, s2: rd_b, mode: opcode, dest: instr[3:2]};
            vld  <= 1'b1;
          end
        endcase
      end
    end else if (out_ready) begin
      vld <= 1'b0;
    end
  end

  assign s1        = held.s1;
  assign s2        = held.s2;
  assign mode      = held.mode;
  assign dest      = held.dest;
  assign out_valid = vld;

endmodule

// File: tb/tb_id_stage.sv
// Scoreboard bench for id_stage: a transaction-level model pushes expected ops,
// a negedge monitor pops and compares whenever the DUT presents one.
module tb_id_stage;
  localparam logic [7:0] RST = 8'h5A;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] instr = '0;
  logic       instr_valid = 1'b0;
  logic       instr_ready;
  logic       flush = 1'b0;
  logic       wb_en = 1'b0;
  logic [1:0] wb_addr = '0;
  logic [7:0] wb_data = '0;
  logic [7:0] s1, s2;
  logic [3:0] mode;
  logic [1:0] dest;
  logic       out_valid;
  logic       out_ready = 1'b1;

  always #5 clk = ~clk;

  id_stage #(.REG_RST_VAL(RST)) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .flush(flush), .wb_en(wb_en), .wb_addr(wb_addr),
    .wb_data(wb_data), .s1(s1), .s2(s2), .mode(mode), .dest(dest),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  typedef struct {
    logic [7:0] s1;
    logic [7:0] s2;
    logic [3:0] mode;
    logic [1:0] dest;
  } exp_t;

  exp_t       q[$];
  logic [7:0] regs[4] = '{RST, RST, RST, RST};
  bit         m_vld = 0;
  bit         pend = 0;
  logic [1:0] pra = '0;
  int         n_chk = 0;
  int         n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
  endtask

  function automatic logic [7:0] rd(input logic [1:0] x);
`ifdef ID_WB_BYPASS_EN
    if (wb_en && wb_addr == x) return wb_data;
`endif
    return regs[x];
  endfunction

  // Reference model: one step per rising edge, using the inputs of that cycle.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs  = '{RST, RST, RST, RST};
      m_vld = 0;
      pend  = 0;
      q.delete();
    end else begin
      bit   acc;
      exp_t e;
      acc = instr_valid && (!m_vld || out_ready);
      if (flush) begin
        if (m_vld && !out_ready && q.size() != 0) void'(q.pop_back());
        m_vld = 0;
        pend  = 0;
      end else if (acc) begin
        if (pend) begin
          e = '{rd(pra), instr, 4'hF, pra};
          q.push_back(e);
          m_vld = 1;
          pend  = 0;
        end else if (instr[7:4] == 4'h0) begin
          m_vld = 0;
        end else if (instr[7:4] == 4'hF) begin
          pra   = instr[3:2];
          pend  = 1;
          m_vld = 0;
        end else begin
          e = '{rd(instr[3:2]), rd(instr[1:0]), instr[7:4], instr[3:2]};
          q.push_back(e);
          m_vld = 1;
        end
      end else if (out_ready) begin
        m_vld = 0;
      end
      if (wb_en) regs[wb_addr] = wb_data;
    end
  end

  always @(negedge clk) begin
    chk("instr_ready", instr_ready, !m_vld || out_ready);
    if (!rst_n) begin
      chk("rst_out_valid", out_valid, 0);
      chk("rst_s1", s1, 0);
      chk("rst_s2", s2, 0);
      chk("rst_mode", mode, 0);
      chk("rst_dest", dest, 0);
    end else begin
      chk("out_valid", out_valid, q.size() != 0);
      if (out_valid && q.size() != 0) begin
        chk("s1", s1, q[0].s1);
        chk("s2", s2, q[0].s2);
        chk("mode", mode, q[0].mode);
        chk("dest", dest, q[0].dest);
        if (out_ready) void'(q.pop_front());
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] b);
    instr = b;
    instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
  endtask

  task automatic wb(input logic [1:0] a, input logic [7:0] d);
    wb_en = 1'b1; wb_addr = a; wb_data = d;
    step();
    wb_en = 1'b0;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    step(3);
    rst_n = 1'b1;
    step();

    // registers hold the reset value before any writeback
    send(8'h1B);
    step();

    wb(2'd1, 8'h05);
    wb(2'd2, 8'h03);
    send(8'h16);
    step();

    send(8'hF8);
    send(8'h7F);

    // stall with a writeback to a held source, then release
    out_ready = 1'b0;
    step();
    instr = 8'h36; instr_valid = 1'b1;
    wb_en = 1'b1; wb_addr = 2'd1; wb_data = 8'hAA;
    step();
    wb_en = 1'b0;
    step(2);
    out_ready = 1'b1;
    step();
    instr_valid = 1'b0;
    step();

    // flush drops a pending LoadIMM and the byte offered alongside it
    send(8'hF4);
    instr = 8'h22; instr_valid = 1'b1; flush = 1'b1;
    step();
    flush = 1'b0; instr_valid = 1'b0;
    send(8'h26);
    step();

    // same-cycle writeback and read of R3
    instr = 8'h8F; instr_valid = 1'b1;
    wb_en = 1'b1; wb_addr = 2'd3; wb_data = 8'h11;
    step();
    wb_en = 1'b0; instr_valid = 1'b0;
    step();

    // flush of a stalled held op
    out_ready = 1'b0;
    send(8'h45);
    flush = 1'b1;
    step();
    flush = 1'b0; out_ready = 1'b1;
    step();

    // reset in the middle of LoadIMM
    send(8'hF4);
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    send(8'h9E);
    step();

    for (int i = 0; i < 3000; i++) begin
      instr       = 8'($urandom);
      instr_valid = ($urandom % 4) != 0;
      out_ready   = ($urandom % 3) != 0;
      flush       = ($urandom % 16) == 0;
      wb_en       = ($urandom % 3) == 0;
      wb_addr     = 2'($urandom);
      wb_data     = 8'($urandom);
      step();
    end

    instr_valid = 1'b0; flush = 1'b0; wb_en = 1'b0; out_ready = 1'b1;
    step(4);
    chk("drain_empty", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
